// File: rtl/sodor5_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sodor5_pkg
//  Description : Shared definitions for the sodor5_verif RV32I lockstep core:
//                opcode/funct constants, ALU operation encoding, decoded
//                instruction and pipeline stage-register structures, and the
//                instruction decode helpers used by both the pipeline and the
//                optional shadow checker.
//  Revision    : 1.0 - initial release
// ============================================================================
package sodor5_pkg;

    // Datapath width the stage structures are built for (RV32I).
    localparam int RV_XLEN = 32;

    // Canonical NOP: ADDI x0, x0, 0.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Major opcodes handled by this core.
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    // funct3 codes shared by OP and OP-IMM.
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // funct7 values: base encoding and the SUB/SRA alternate encoding.
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    // Result of decoding one instruction word.
    typedef struct packed {
        logic    legal;
        alu_op_e alu_op;
        logic    use_imm;
    } dec_t;

    // Execute-stage register: operands already resolved through the bypass.
    typedef struct packed {
        logic               valid;
        logic               legal;
        alu_op_e            alu_op;
        logic               use_imm;
        logic [31:0]        instr;
        logic [4:0]         rd;
        logic [RV_XLEN-1:0] rs1_val;
        logic [RV_XLEN-1:0] rs2_val;
    } ex_stage_t;

    // Memory / writeback stage register: result already final (0 for x0).
    typedef struct packed {
        logic               valid;
        logic               legal;
        logic [31:0]        instr;
        logic [4:0]         rd;
        logic [RV_XLEN-1:0] result;
    } wb_stage_t;

    // Register-register and shift-immediate ops share this funct3 mapping.
    function automatic alu_op_e f3_to_op(input logic [2:0] f3);
        alu_op_e op;
        case (f3)
            F3_ADD_SUB: op = ALU_ADD;
            F3_SLL:     op = ALU_SLL;
            F3_SLT:     op = ALU_SLT;
            F3_SLTU:    op = ALU_SLTU;
            F3_XOR:     op = ALU_XOR;
            F3_SRL_SRA: op = ALU_SRL;
            F3_OR:      op = ALU_OR;
            default:    op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic dec_t decode_instr(input logic [6:0] opc,
                                          input logic [2:0] f3,
                                          input logic [6:0] f7);
        dec_t d;
        d = '{legal: 1'b0, alu_op: ALU_ADD, use_imm: 1'b0};
        if (opc == OPC_OP) begin
            if (f7 == F7_BASE) begin
                d.legal  = 1'b1;
                d.alu_op = f3_to_op(f3);
            end else if (f7 == F7_ALT && f3 == F3_ADD_SUB) begin
                d.legal  = 1'b1;
                d.alu_op = ALU_SUB;
            end else if (f7 == F7_ALT && f3 == F3_SRL_SRA) begin
                d.legal  = 1'b1;
                d.alu_op = ALU_SRA;
            end
        end else if (opc == OPC_OP_IMM) begin
            d.use_imm = 1'b1;
            case (f3)
                // Shift-immediates reuse imm[11:5] as funct7; only the two
                // defined patterns are legal.
                F3_SLL: begin
                    if (f7 == F7_BASE) begin
                        d.legal  = 1'b1;
                        d.alu_op = ALU_SLL;
                    end
                end
                F3_SRL_SRA: begin
                    if (f7 == F7_BASE) begin
                        d.legal  = 1'b1;
                        d.alu_op = ALU_SRL;
                    end else if (f7 == F7_ALT) begin
                        d.legal  = 1'b1;
                        d.alu_op = ALU_SRA;
                    end
                end
                default: begin
                    d.legal  = 1'b1;
                    d.alu_op = f3_to_op(f3);
                end
            endcase
        end
        return d;
    endfunction

    // I-type immediate, sign-extended from instr[31:20].
    function automatic logic [RV_XLEN-1:0] imm_i(input logic [11:0] imm12);
        return {{(RV_XLEN-12){imm12[11]}}, imm12};
    endfunction

endpackage : sodor5_pkg
`default_nettype wire

// File: rtl/sodor5_alu.sv
`default_nettype none
// ============================================================================
//  Module      : sodor5_alu
//  Description : Purely combinational RV32I integer ALU. Shared by the
//                pipeline execute stage and the optional shadow checker.
//  Ports       : alu_op [3:0]      - operation, encoded as sodor5_pkg::alu_op_e
//                a, b   [XLEN-1:0] - operands (shift amount is b[4:0])
//                result [XLEN-1:0] - operation result, wraps modulo 2^XLEN
//  Revision    : 1.0 - initial release
// ============================================================================
module sodor5_alu
    import sodor5_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result
);

    logic [4:0] w_shamt;
    logic       w_lt_s;
    logic       w_lt_u;

    assign w_shamt = b[4:0];
    assign w_lt_s  = $signed(a) < $signed(b);
    assign w_lt_u  = a < b;

    always_comb begin
        result = '0;
        case (alu_op_e'(alu_op))
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << w_shamt;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, w_lt_s};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, w_lt_u};
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> w_shamt;
            ALU_SRA:  result = $signed(a) >>> w_shamt;
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = '0;
        endcase
    end

endmodule : sodor5_alu
`default_nettype wire

// File: rtl/sodor5_verif.sv
`default_nettype none
// ============================================================================
//  Module      : sodor5_verif
//  Description : 5-stage (F/D/E/M/W) in-order RV32I OP / OP-IMM pipeline with
//                full bypassing and a commit port for lockstep comparison.
//                One instruction accepted per cycle, no stalls.
//  Ports       : clk, reset          - clock, synchronous active-high reset
//                instr[31:0]         - instruction word, captured into D
//                commit_valid        - W-stage instruction retires this cycle
//                commit_instr/rd/data- retiring word, destination, value
//                illegal             - W-stage instruction was unsupported
//                dbg_raddr/dbg_rdata - asynchronous architectural reg read
//                mismatch            - sticky shadow-check failure flag
//  Build       : define SODOR5_CHECK_EN to add the single-cycle ISA shadow
//                regfile that drives mismatch; otherwise mismatch is 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module sodor5_verif
    import sodor5_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     instr,
    output logic            commit_valid,
    output logic [31:0]     commit_instr,
    output logic [4:0]      commit_rd,
    output logic [XLEN-1:0] commit_data,
    output logic            illegal,
    input  logic [4:0]      dbg_raddr,
    output logic [XLEN-1:0] dbg_rdata,
    output logic            mismatch
);

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic        r_d_valid;
    logic [31:0] r_d_instr;
    ex_stage_t   r_e;
    wb_stage_t   r_m;
    wb_stage_t   r_w;

    // Architectural regfile; deliberately not reset so contents survive.
    logic [XLEN-1:0] r_regs [NREGS];

    // ------------------------------------------------------------------
    // D stage: decode and operand resolution
    // ------------------------------------------------------------------
    dec_t            w_d_dec;
    logic [4:0]      w_rs   [2];
    logic [XLEN-1:0] w_opnd [2];

    assign w_d_dec = decode_instr(r_d_instr[6:0], r_d_instr[14:12], r_d_instr[31:25]);
    assign w_rs[0] = r_d_instr[19:15];
    assign w_rs[1] = r_d_instr[24:20];

    // A stage may forward only if it will actually write a non-zero rd.
    logic            w_e_wr;
    logic            w_m_wr;
    logic            w_w_wr;
    logic [XLEN-1:0] w_e_result;

    assign w_e_wr = r_e.valid & r_e.legal & (r_e.rd != 5'd0);
    assign w_m_wr = r_m.valid & r_m.legal & (r_m.rd != 5'd0);
    assign w_w_wr = r_w.valid & r_w.legal & (r_w.rd != 5'd0);

    // Youngest producer wins: E, then M, then W, then the regfile. The W
    // path covers the cycle before the regfile write lands.
    for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
        logic [4:0]      w_sel;
        logic [XLEN-1:0] w_val;

        assign w_sel = w_rs[gi];
        assign w_val = (w_sel == 5'd0)                ? '0 :
                       (w_e_wr && r_e.rd == w_sel)    ? w_e_result :
                       (w_m_wr && r_m.rd == w_sel)    ? r_m.result :
                       (w_w_wr && r_w.rd == w_sel)    ? r_w.result :
                                                        r_regs[w_sel];
        assign w_opnd[gi] = w_val;
    end

    // ------------------------------------------------------------------
    // E stage: ALU
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_e_b;

    assign w_e_b = r_e.use_imm ? imm_i(r_e.instr[31:20]) : r_e.rs2_val;

    sodor5_alu #(
        .XLEN   (XLEN)
    ) u_alu (
        .alu_op (r_e.alu_op),
        .a      (r_e.rs1_val),
        .b      (w_e_b),
        .result (w_e_result)
    );

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_d_valid <= 1'b0;
            r_d_instr <= NOP_INSTR;
            r_e       <= '0;
            r_m       <= '0;
            r_w       <= '0;
        end else begin
            r_d_valid <= 1'b1;
            r_d_instr <= instr;

            r_e <= '{valid:   r_d_valid,
                     legal:   w_d_dec.legal,
                     alu_op:  w_d_dec.alu_op,
                     use_imm: w_d_dec.use_imm,
                     instr:   r_d_instr,
                     rd:      r_d_instr[11:7],
                     rs1_val: w_opnd[0],
                     rs2_val: w_opnd[1]};

            // Result forced to 0 for x0 so commit_data reports 0 there.
            r_m <= '{valid:  r_e.valid,
                     legal:  r_e.legal,
                     instr:  r_e.instr,
                     rd:     r_e.rd,
                     result: (r_e.rd == 5'd0) ? '0 : w_e_result};

            r_w <= r_m;
        end
    end

    // ------------------------------------------------------------------
    // W stage: regfile write and commit port
    // ------------------------------------------------------------------
    // Gating by reset squashes the W instruction on the reset edge itself.
    logic w_w_live;

    assign w_w_live = r_w.valid & ~reset;

    always_ff @(posedge clk) begin
        if (w_w_live && w_w_wr) begin
            r_regs[r_w.rd] <= r_w.result;
        end
    end

    assign commit_valid = w_w_live & r_w.legal;
    assign commit_instr = commit_valid ? r_w.instr  : 32'd0;
    assign commit_rd    = commit_valid ? r_w.rd     : 5'd0;
    assign commit_data  = commit_valid ? r_w.result : '0;
    assign illegal      = w_w_live & ~r_w.legal;

    assign dbg_rdata = (dbg_raddr == 5'd0) ? '0 : r_regs[dbg_raddr];

    // ------------------------------------------------------------------
    // Optional shadow checker
    // ------------------------------------------------------------------
`ifdef SODOR5_CHECK_EN
    // Single-cycle ISA model: re-executes each committed word against its
    // own register copy, independent of the pipeline bypass network.
    logic [XLEN-1:0] r_shadow [NREGS];
    logic            r_mismatch;
    dec_t            w_sh_dec;
    logic [4:0]      w_sh_rs1;
    logic [4:0]      w_sh_rs2;
    logic [XLEN-1:0] w_sh_a;
    logic [XLEN-1:0] w_sh_b;
    logic [XLEN-1:0] w_sh_result;
    logic [XLEN-1:0] w_sh_expect;

    assign w_sh_dec = decode_instr(commit_instr[6:0], commit_instr[14:12],
                                   commit_instr[31:25]);
    assign w_sh_rs1 = commit_instr[19:15];
    assign w_sh_rs2 = commit_instr[24:20];
    assign w_sh_a   = (w_sh_rs1 == 5'd0) ? '0 : r_shadow[w_sh_rs1];
    assign w_sh_b   = w_sh_dec.use_imm ? imm_i(commit_instr[31:20]) :
                      (w_sh_rs2 == 5'd0) ? '0 : r_shadow[w_sh_rs2];

    sodor5_alu #(
        .XLEN   (XLEN)
    ) u_shadow_alu (
        .alu_op (w_sh_dec.alu_op),
        .a      (w_sh_a),
        .b      (w_sh_b),
        .result (w_sh_result)
    );

    assign w_sh_expect = (commit_rd == 5'd0) ? '0 : w_sh_result;

    always_ff @(posedge clk) begin
        if (commit_valid && commit_rd != 5'd0) begin
            r_shadow[commit_rd] <= w_sh_expect;
        end
    end

    // A commit the model considers illegal is also a divergence.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mismatch <= 1'b0;
        end else if (commit_valid &&
                     (!w_sh_dec.legal || commit_data != w_sh_expect)) begin
            r_mismatch <= 1'b1;
        end
    end

    assign mismatch = r_mismatch;
`else
    assign mismatch = 1'b0;
`endif

endmodule : sodor5_verif
`default_nettype wire

// File: tb/tb_sodor5_verif.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sodor5_verif
//  Description : Directed self-checking bench for sodor5_verif. Registers are
//                preloaded with ADDI instructions, then dependent OP/OP-IMM
//                sequences, illegal words and a mid-flight reset are issued.
//                After the tick for issue slot k the W stage holds slot k-3.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sodor5_verif;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        commit_valid;
    logic [31:0] commit_instr;
    logic [4:0]  commit_rd;
    logic [31:0] commit_data;
    logic        illegal;
    logic [4:0]  dbg_raddr;
    logic [31:0] dbg_rdata;
    logic        mismatch;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sodor5_verif #(
        .XLEN         (32),
        .NREGS        (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .instr        (instr),
        .commit_valid (commit_valid),
        .commit_instr (commit_instr),
        .commit_rd    (commit_rd),
        .commit_data  (commit_data),
        .illegal      (illegal),
        .dbg_raddr    (dbg_raddr),
        .dbg_rdata    (dbg_rdata),
        .mismatch     (mismatch)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present a word, let it be captured, then sample 1 ns after the edge.
    task automatic tick(input logic [31:0] w);
        instr = w;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_commit(input string tag, input logic [31:0] ins,
                              input logic [4:0] rd, input logic [31:0] data);
        chk({tag, ".valid"},   {31'd0, commit_valid}, 32'd1);
        chk({tag, ".illegal"}, {31'd0, illegal},      32'd0);
        chk({tag, ".instr"},   commit_instr,          ins);
        chk({tag, ".rd"},      {27'd0, commit_rd},    {27'd0, rd});
        chk({tag, ".data"},    commit_data,           data);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".valid"},   {31'd0, commit_valid}, 32'd0);
        chk({tag, ".illegal"}, {31'd0, illegal},      32'd0);
    endtask

    task automatic chk_illegal(input string tag);
        chk({tag, ".valid"},   {31'd0, commit_valid}, 32'd0);
        chk({tag, ".illegal"}, {31'd0, illegal},      32'd1);
    endtask

    task automatic chk_reg(input string tag, input logic [4:0] r, input logic [31:0] exp);
        dbg_raddr = r;
        #1;
        chk(tag, dbg_rdata, exp);
    endtask

    initial begin
        reset     = 1'b1;
        instr     = NOP;
        dbg_raddr = 5'd0;

        // Reset state
        tick(NOP);
        tick(NOP);
        tick(NOP);
        chk("rst.valid",    {31'd0, commit_valid}, 32'd0);
        chk("rst.illegal",  {31'd0, illegal},      32'd0);
        chk("rst.instr",    commit_instr,          32'd0);
        chk("rst.rd",       {27'd0, commit_rd},    32'd0);
        chk("rst.data",     commit_data,           32'd0);
        chk("rst.mismatch", {31'd0, mismatch},     32'd0);
        reset = 1'b0;

        // Preload x2=5, x3=7, then add x1,x2,x3 and add x3,x3,x1
        tick(32'h0050_0113);  chk_idle("empty1");
        tick(32'h0070_0193);
        tick(32'h0031_00B3);
        tick(32'h0011_81B3);  chk_commit("addi_x2", 32'h0050_0113, 5'd2, 32'd5);
        tick(NOP);            chk_commit("addi_x3", 32'h0070_0193, 5'd3, 32'd7);
        tick(NOP);            chk_commit("add_x1",  32'h0031_00B3, 5'd1, 32'd12);
        tick(NOP);            chk_commit("add_x3_byp", 32'h0011_81B3, 5'd3, 32'd19);
                              chk_reg("rf_x1", 5'd1, 32'd12);
        tick(32'h0011_0033);  chk_commit("nop_a", NOP, 5'd0, 32'd0);
                              chk_reg("rf_x3", 5'd3, 32'd19);

        // x1=0x80000000 (addi+slli), x2=4, sub, re-set x2=4, sra
        tick(32'h0010_0093);  chk_commit("nop_b", NOP, 5'd0, 32'd0);
        tick(32'h01F0_9093);  chk_commit("nop_c", NOP, 5'd0, 32'd0);
        tick(32'h0040_0113);  chk_commit("add_x0", 32'h0011_0033, 5'd0, 32'd0);
                              chk_reg("rf_x0", 5'd0, 32'd0);
        tick(32'h4020_8133);  chk_commit("addi_x1", 32'h0010_0093, 5'd1, 32'd1);
        tick(32'h0040_0113);  chk_commit("slli_x1", 32'h01F0_9093, 5'd1, 32'h8000_0000);
        tick(32'h4020_D1B3);  chk_commit("addi_x2a", 32'h0040_0113, 5'd2, 32'd4);
        tick(32'h0000_0000);  chk_commit("sub_x2", 32'h4020_8133, 5'd2, 32'h7FFF_FFFC);
        tick(32'h4020_90B3);  chk_commit("addi_x2b", 32'h0040_0113, 5'd2, 32'd4);
        tick(NOP);            chk_commit("sra_x3", 32'h4020_D1B3, 5'd3, 32'hF800_0000);

        // Illegal words: all-zero, and OP with funct7=0100000 funct3=001 rd=x1
        tick(NOP);            chk_illegal("ill_zero");
                              chk_reg("rf_x3_sra", 5'd3, 32'hF800_0000);
        tick(NOP);            chk_illegal("ill_f7");
        tick(NOP);            chk_commit("nop_d", NOP, 5'd0, 32'd0);
                              chk_reg("rf_x1_kept", 5'd1, 32'h8000_0000);
                              chk_reg("rf_x2_kept", 5'd2, 32'd4);

        // Reset two cycles after issuing add x1,x2,x3: it must never commit
        tick(32'h0031_00B3);  chk_commit("nop_e", NOP, 5'd0, 32'd0);
        tick(NOP);            chk_commit("nop_f", NOP, 5'd0, 32'd0);
        reset = 1'b1;
        tick(NOP);            chk_idle("rst2_a");
        tick(NOP);            chk_idle("rst2_b");
                              chk_reg("rf_x1_rst", 5'd1, 32'h8000_0000);
        reset = 1'b0;

        // addi x5,x0,-1 then compare/logic/shift ops
        tick(32'hFFF0_0293);  chk_idle("post_a");
        tick(32'h0050_A333);  chk_idle("post_b");
        tick(32'h0012_B3B3);  chk_idle("post_c");
        tick(32'h01F0_D413);  chk_commit("addi_x5", 32'hFFF0_0293, 5'd5,  32'hFFFF_FFFF);
        tick(32'h0F02_C493);  chk_commit("slt_x6",  32'h0050_A333, 5'd6,  32'd1);
        tick(32'hFFF0_B513);  chk_commit("sltu_x7", 32'h0012_B3B3, 5'd7,  32'd0);
        tick(32'h0012_F5B3);  chk_commit("srli_x8", 32'h01F0_D413, 5'd8,  32'd1);
        tick(32'h41F0_D613);  chk_commit("xori_x9", 32'h0F02_C493, 5'd9,  32'hFFFF_FF0F);
        tick(NOP);            chk_commit("sltiu_x10", 32'hFFF0_B513, 5'd10, 32'd1);
        tick(NOP);            chk_commit("and_x11", 32'h0012_F5B3, 5'd11, 32'h8000_0000);
        tick(NOP);            chk_commit("srai_x12", 32'h41F0_D613, 5'd12, 32'hFFFF_FFFF);
        tick(NOP);            chk_commit("nop_g", NOP, 5'd0, 32'd0);
                              chk_reg("rf_x12", 5'd12, 32'hFFFF_FFFF);
                              chk_reg("rf_x9",  5'd9,  32'hFFFF_FF0F);
        chk("end.mismatch", {31'd0, mismatch}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_sodor5_verif
`default_nettype wire
